alu_hs: RTL and testbench

Parametrised, registered successor to the team's 8-bit combinational ALU. It takes one operation per valid/ready handshake and returns a registered result with `carry` and `zero` flags on a second valid/ready handshake. Operand width is configurable. It adds two new operations: an iterative multi-cycle unsigned multiply and a single-cycle signed saturating add. It sits between an operand-issue stage and a writeback/consumer stage and tolerates backpressure on both sides.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_hs.sv | 148 ++++++++++++++
 tb/tb_alu_hs.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the handshaked ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_AND    = 4'b0010;
  localparam logic [3:0] OP_OR     = 4'b0011;
  localparam logic [3:0] OP_NOT    = 4'b0100;
  localparam logic [3:0] OP_XOR    = 4'b0101;
  localparam logic [3:0] OP_NOR    = 4'b0110;
  localparam logic [3:0] OP_SHL    = 4'b0111;
  localparam logic [3:0] OP_SHR    = 4'b1000;
  localparam logic [3:0] OP_ASR    = 4'b1001;
  localparam logic [3:0] OP_ROL    = 4'b1010;
  localparam logic [3:0] OP_ROR    = 4'b1011;
  localparam logic [3:0] OP_EQ     = 4'b1100;
  localparam logic [3:0] OP_MUL    = 4'b1101;
  localparam logic [3:0] OP_SATADD = 4'b1110;
  localparam logic [3:0] OP_ZERO   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles after start. done/product are valid during the last iteration
// so the caller can register the result on the same edge.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign busy    = busy_q;
  assign product = acc_d;

  // Load operands on start, then accumulate one shifted multiplicand per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_hs.sv
// Registered ALU with valid/ready on both request and result sides.
// Single-cycle ops return one edge after accept; multiply runs WIDTH edges
// through alu_mul_iter. Results hold in DONE until the consumer takes them.
module alu_hs
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  state_e             state_q;
  logic [WIDTH-1:0]   out_q;
  logic               carry_q;
  logic               zero_q;
  logic               out_valid_q;

  logic [WIDTH-1:0]   res_d;
  logic               carry_d;
  logic               zero_d;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic               accept_w;
  logic               mul_busy_w;
  logic               mul_done_w;
  logic [2*WIDTH-1:0] mul_prod_w;

  // Signed add clamped to the representable range; MSB of the return is the
  // clamp flag, the rest is the clamped value.
  function automatic logic [WIDTH:0] sat_add(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    logic                  ovf;
    logic [WIDTH-1:0]      v;
    s   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    ovf = s[WIDTH] ^ s[WIDTH-1];
    if (!ovf)          v = s[WIDTH-1:0];
    else if (s[WIDTH]) v = {1'b1, {(WIDTH-1){1'b0}}};
    else               v = {1'b0, {(WIDTH-1){1'b1}}};
    return {ovf, v};
  endfunction

  assign sum_w  = {x[WIDTH-1], x} + {y[WIDTH-1], y};
  assign diff_w = {x[WIDTH-1], x} - {y[WIDTH-1], y};

  // The multiplier's busy flag is redundant with the MUL state but also
  // blocks issue defensively should the two ever disagree.
  assign in_ready = rst_n && !mul_busy_w &&
                    ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept_w = in_valid && in_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept_w && (ctrl == OP_MUL)),
    .a       (x),
    .b       (y),
    .busy    (mul_busy_w),
    .done    (mul_done_w),
    .product (mul_prod_w)
  );

  // Single-cycle op decoder; multiply and 1111 fall through to zero.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    case (ctrl)
      OP_ADD:    {carry_d, res_d} = sum_w;
      OP_SUB:    {carry_d, res_d} = diff_w;
      OP_AND:    res_d = x & y;
      OP_OR:     res_d = x | y;
      OP_NOT:    res_d = ~x;
      OP_XOR:    res_d = x ^ y;
      OP_NOR:    res_d = ~(x | y);
      OP_SHL:    res_d = y << x[SHW-1:0];
      OP_SHR:    res_d = y >> x[SHW-1:0];
      OP_ASR:    res_d = {x[WIDTH-1], x[WIDTH-1:1]};
      OP_ROL:    res_d = {x[WIDTH-2:0], x[WIDTH-1]};
      OP_ROR:    res_d = {x[0], x[WIDTH-1:1]};
      OP_EQ:     res_d = (x == y) ? WIDTH'(1) : '0;
      OP_SATADD: {carry_d, res_d} = sat_add(x, y);
      default:   res_d = '0;
    endcase
    zero_d = (res_d == '0);
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept_w) begin
            if (ctrl == OP_MUL) begin
              state_q     <= MUL;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_q       <= res_d;
              carry_q     <= carry_d;
              zero_q      <= zero_d;
            end
          end else if ((state_q == DONE) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done_w) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_q       <= mul_prod_w[WIDTH-1:0];
            carry_q     <= |mul_prod_w[2*WIDTH-1:WIDTH];
            zero_q      <= (mul_prod_w[WIDTH-1:0] == '0);
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_hs.sv
// Directed bench for alu_hs at WIDTH = 8.
module tb_alu_hs;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ctrl;
  logic [7:0] x;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       carry;
  logic       zero;

  int errs   = 0;
  int checks = 0;

  alu_hs #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one single-cycle op from IDLE, check latency-1 result, then drain.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] eo, input logic ec,
                        input logic ez);
    out_ready = 1'b0;
    ctrl = op; x = a; y = b; in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out"},   32'(out),       32'(eo));
    check({tag, "_carry"}, 32'(carry),     32'(ec));
    check({tag, "_zero"},  32'(zero),      32'(ez));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  // Count edges after the accept edge until out_valid, checking in_ready stays low.
  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctrl = 4'h0; x = 8'h00; y = 8'h00;
    tick(); tick();

    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out",       32'(out),       32'd0);
    check("rst_carry",     32'(carry),     32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // add / sub with sign-extended carry
    run_op("add_ff_ff", 4'b0000, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);
    run_op("add_7f_01", 4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
    run_op("add_ff_01", 4'b0000, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1);
    run_op("sub_05_07", 4'b0001, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);

    // saturating add
    run_op("sat_70_20", 4'b1110, 8'h70, 8'h20, 8'h7F, 1'b1, 1'b0);
    run_op("sat_80_f0", 4'b1110, 8'h80, 8'hF0, 8'h80, 1'b1, 1'b0);
    run_op("sat_10_20", 4'b1110, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);

    // shifts, rotates and logic
    run_op("shl",  4'b0111, 8'h0B, 8'h81, 8'h08, 1'b0, 1'b0);
    run_op("shr",  4'b1000, 8'h0A, 8'h80, 8'h20, 1'b0, 1'b0);
    run_op("asr",  4'b1001, 8'h82, 8'h00, 8'hC1, 1'b0, 1'b0);
    run_op("rol",  4'b1010, 8'h81, 8'h00, 8'h03, 1'b0, 1'b0);
    run_op("ror",  4'b1011, 8'h01, 8'h00, 8'h80, 1'b0, 1'b0);
    run_op("not",  4'b0100, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0);
    run_op("nor",  4'b0110, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0);
    run_op("eq",   4'b1100, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0);
    run_op("neq",  4'b1100, 8'h5A, 8'h5B, 8'h00, 1'b0, 1'b1);
    run_op("op_f", 4'b1111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);

    // multiply 0x10 * 0x20 = 0x0200
    out_ready = 1'b0;
    ctrl = 4'b1101; x = 8'h10; y = 8'h20; in_valid = 1'b1;
    check("mul1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_valid("mul1", cyc);
    check("mul1_latency", 32'(cyc),   32'd8);
    check("mul1_out",     32'(out),   32'h00);
    check("mul1_carry",   32'(carry), 32'd1);
    check("mul1_zero",    32'(zero),  32'd1);

    // backpressure: result held, a pending request is not taken
    ctrl = 4'b0000; x = 8'h01; y = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(in_ready),  32'd0);
      tick();
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_out",      32'(out),       32'h00);
      check("bp_carry",    32'(carry),     32'd1);
      check("bp_zero",     32'(zero),      32'd1);
    end

    // stream four single-cycle ops back to back
    out_ready = 1'b1;
    #1;
    check("st_in_ready0", 32'(in_ready), 32'd1);
    tick();
    check("st_add",   32'(out), 32'h02);
    check("st_add_v", 32'(out_valid), 32'd1);
    ctrl = 4'b0101; x = 8'hF0; y = 8'h3C;
    check("st_in_ready1", 32'(in_ready), 32'd1);
    tick();
    check("st_xor",   32'(out), 32'hCC);
    check("st_xor_v", 32'(out_valid), 32'd1);
    ctrl = 4'b0010; x = 8'hF0; y = 8'h3C;
    tick();
    check("st_and",   32'(out), 32'h30);
    check("st_and_v", 32'(out_valid), 32'd1);
    ctrl = 4'b0011; x = 8'h0F; y = 8'hF0;
    tick();
    check("st_or",    32'(out), 32'hFF);
    check("st_or_v",  32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    check("st_drained", 32'(out_valid), 32'd0);

    // multiply 0x0F * 0x0F = 0x00E1
    out_ready = 1'b0;
    ctrl = 4'b1101; x = 8'h0F; y = 8'h0F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("mul2", cyc);
    check("mul2_latency", 32'(cyc),   32'd8);
    check("mul2_out",     32'(out),   32'hE1);
    check("mul2_carry",   32'(carry), 32'd0);
    check("mul2_zero",    32'(zero),  32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mul2_drained", 32'(out_valid), 32'd0);

    // reset during iteration 4 of a multiply
    ctrl = 4'b1101; x = 8'h0F; y = 8'h0F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    check("mrst_valid",    32'(out_valid), 32'd0);
    check("mrst_out",      32'(out),       32'd0);
    check("mrst_carry",    32'(carry),     32'd0);
    check("mrst_zero",     32'(zero),      32'd0);
    check("mrst_in_ready", 32'(in_ready),  32'd0);
    rst_n = 1'b1;
    #1;
    check("mrst_idle_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mrst_no_result", 32'(out_valid), 32'd0);
    end
    run_op("post_rst_add", 4'b0000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
